unidad_control_multiciclo: RTL and testbench
============================================

# unidad_control_multiciclo

Multicycle main controller for the ARM-subset processor. It sequences each instruction through fetch, decode, execute, memory and writeback states, drives the datapath mux selects, and produces the ungated `FlagW`, `PCS`, `RegW`, `MemW` and `NextPC` requests. The downstream conditional unit qualifies these requests with the condition check. The block sits between the instruction register fields and the conditional unit.

## Interface
Parameters: none.

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `Op`  in  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
- `Funct`  in  6  Instr[25:20]: [5] I bit, [4:1] cmd, [0] S (data-processing) or L (memory)
- `Rd`  in  4  Instr[15:12]
- `IRWrite`  out  1  load instruction register
- `NextPC`  out  1  unconditional PC update (fetch)
- `AdrSrc`  out  1  memory address: 0 = PC, 1 = ALUOut
- `ALUSrcA`  out  1  0 = RD1 register, 1 = PC
- `ALUSrcB`  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUControl`  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- `FlagW`  out  2  [1] = NZ write request, [0] = CV write request
- `PCS`  out  1  PC-source request (branch or write to R15)
- `RegW`  out  1  register-file write request
- `MemW`  out  1  data-memory write request
- `ImmSrc`  out  2  equals `Op`
- `RegSrc`  out  2  [0] = (Op==10), [1] = (Op==01)

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 with Funct[5]=0→EXECUTER; Op=00 with Funct[5]=1→EXECUTEI; Op=10→BRANCH; Op=11→FETCH (NOP).
  - MEMADR: Funct[0]=1→MEMRD, else →MEMWR.
  - MEMRD→MEMWB→FETCH; MEMWR→FETCH; EXECUTER/EXECUTEI→ALUWB→FETCH; BRANCH→FETCH.
- Moore outputs per state (signals not listed are 0):
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - ALUOp=0 → ALUControl=00, FlagW=00.
  - ALUOp=1 → ALUControl from cmd: 0100→00, 0010→01, 0000→10, 1100→11. Any other cmd → ALUControl=00 and FlagW=00.
  - FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ADD|SUB).
- PCS = (RegW & Rd==4'hF) | Branch.

## Timing
- Async reset forces state=FETCH immediately, independent of `clk`.
- While reset is high: IRWrite, NextPC, RegW, MemW, PCS and FlagW are forced to 0. All selects take FETCH values (AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00).
- First FETCH cycle is the first full cycle after reset deasserts.
- Instruction latency in cycles: data-processing 4, LDR 5, STR 4, branch 3, undefined 2.
- State changes on the rising `clk` edge only.
- Op/Funct/Rd are sampled only from DECODE onward. They must be stable from the edge ending FETCH until the instruction returns to FETCH; the IR guarantees this.
- Outputs are combinational from state and inputs with no registered delay. FlagW is valid only in EXECUTER/EXECUTEI.
- Reset asserted mid-instruction abandons the instruction; no write request is issued after the asserting edge.

## Structure
- Package `control_pkg`:
  - `estado_t` enum for the 10 states.
  - ALUControl localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR).
  - Op localparams (OP_DP, OP_MEM, OP_BR).
  - ALUSrcB and ResultSrc select encodings.
- One sub-module `decodificador_alu` (combinational): inputs ALUOp, Funct, Rd, RegW, Branch; outputs ALUControl, FlagW, PCS.
- Top level holds the state register, next-state logic and the output decode.

## Test plan
- Reset: pulse reset mid-ALUWB → state=FETCH immediately, RegW=0 during reset; first post-reset cycle IRWrite=1, NextPC=1.
- ADDS R1 (Op=00, Funct=101001, Rd=1) → FETCH, DECODE, EXECUTEI, ALUWB. In EXECUTEI ALUControl=00, FlagW=11; in ALUWB RegW=1, PCS=0.
- ANDS register (Funct=000001) → EXECUTER, FlagW=10, ALUControl=10. SUB into R15 (Funct=000100, Rd=15) → PCS=1 in ALUWB, FlagW=00.
- LDR (Op=01, Funct[0]=1) → five cycles: MEMRD AdrSrc=1, MEMWB ResultSrc=01 with RegW=1. STR (Funct[0]=0) → MEMWR MemW=1, then FETCH.
- Branch (Op=10) → BRANCH with PCS=1, ALUSrcB=01, ResultSrc=10, then FETCH. Op=11 → DECODE→FETCH with no write request asserted.
- Unsupported cmd 1010 with S=1 → ALUControl=00, FlagW=00, still reaches ALUWB.

Source files
------------

// File: rtl/control_pkg.sv
// control_pkg: shared states, opcode fields and datapath select encodings for the multicycle controller
package control_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } estado_t;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] SRCB_RD2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
endpackage

// File: rtl/decodificador_alu.sv
// decodificador_alu: ALU operation, flag-write and PC-source request decode
module decodificador_alu
  import control_pkg::*;
(
  input  logic       ALUOp,
  input  logic [4:0] Funct,
  input  logic [3:0] Rd,
  input  logic       RegW,
  input  logic       Branch,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       PCS
);
  logic known;
  // unsupported commands fall back to ADD and suppress every flag write
  always_comb begin
    known = Funct[4:1] inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR};
    ALUControl = !ALUOp                ? ALU_ADD :
                 Funct[4:1] == CMD_SUB ? ALU_SUB :
                 Funct[4:1] == CMD_AND ? ALU_AND :
                 Funct[4:1] == CMD_ORR ? ALU_ORR : ALU_ADD;
    FlagW = (ALUOp && known) ?
            {Funct[0], Funct[0] & (ALUControl == ALU_ADD || ALUControl == ALU_SUB)} : 2'b00;
    PCS = (RegW && Rd == 4'hF) || Branch;
  end
endmodule

// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: multicycle main FSM driving datapath selects and ungated write requests
module unidad_control_multiciclo
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);
  estado_t state_q, state_d;
  logic alu_op, branch;
  // state register; reset parks the machine in FETCH without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end
  // next-state and Moore outputs; fetch strobes are masked while reset holds
  always_comb begin
    state_d   = FETCH;
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    RegW      = 1'b0;
    MemW      = 1'b0;
    alu_op    = 1'b0;
    branch    = 1'b0;
    case (state_q)
      FETCH: begin
        state_d   = DECODE;
        IRWrite   = !reset;
        NextPC    = !reset;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURESULT;
      end
      DECODE: begin
        state_d   = Op == OP_MEM ? MEMADR :
                    Op == OP_DP  ? (Funct[5] ? EXECUTEI : EXECUTER) :
                    Op == OP_BR  ? BRANCH : FETCH;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURESULT;
      end
      MEMADR: begin
        state_d = Funct[0] ? MEMRD : MEMWR;
        ALUSrcB = SRCB_IMM;
      end
      MEMRD: begin
        state_d = MEMWB;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: begin
        state_d = ALUWB;
        alu_op  = 1'b1;
      end
      EXECUTEI: begin
        state_d = ALUWB;
        ALUSrcB = SRCB_IMM;
        alu_op  = 1'b1;
      end
      ALUWB: RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end
  assign ImmSrc = Op;
  assign RegSrc = {Op == OP_MEM, Op == OP_BR};
  decodificador_alu u_dec (
    .ALUOp      (alu_op),
    .Funct      (Funct[4:0]),
    .Rd         (Rd),
    .RegW       (RegW),
    .Branch     (branch),
    .ALUControl (ALUControl),
    .FlagW      (FlagW),
    .PCS        (PCS)
  );
endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb_unidad_control_multiciclo: scoreboard bench comparing every cycle against an instruction-level model
module tb_unidad_control_multiciclo;
  typedef struct packed {
    logic       ir, npc, adr, srca;
    logic [1:0] srcb, res, aluc, flagw;
    logic       pcs, regw, memw;
    logic [1:0] imm, rsrc;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] Op = '0;
  logic [5:0] Funct = '0;
  logic [3:0] Rd = '0;
  logic IRWrite, NextPC, AdrSrc, ALUSrcA, PCS, RegW, MemW;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW, ImmSrc, RegSrc;
  vec_t actual;
  vec_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  unidad_control_multiciclo dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc)
  );
  assign actual = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
                   FlagW, PCS, RegW, MemW, ImmSrc, RegSrc};
  function automatic int lat(input logic [1:0] op, input logic [5:0] f);
    return op == 2'd0 ? 4 : op == 2'd1 ? (f[0] ? 5 : 4) : op == 2'd2 ? 3 : 2;
  endfunction
  function automatic vec_t model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [3:0] rd, input int c);
    vec_t v;
    logic [1:0] ac;
    logic ok;
    v = '0;
    ac = 2'd0;
    ok = 1'b1;
    v.imm = op;
    v.rsrc = {op == 2'd1, op == 2'd2};
    if (c < 2) begin
      v.ir = (c == 0);
      v.npc = (c == 0);
      v.srca = 1'b1;
      v.srcb = 2'd2;
      v.res = 2'd2;
    end else if (op == 2'd0) begin
      if (c == 2) begin
        case (f[4:1])
          4'd4:  ac = 2'd0;
          4'd2:  ac = 2'd1;
          4'd0:  ac = 2'd2;
          4'd12: ac = 2'd3;
          default: ok = 1'b0;
        endcase
        v.srcb = f[5] ? 2'd1 : 2'd0;
        v.aluc = ac;
        v.flagw = ok ? {f[0], f[0] & (ac < 2'd2)} : 2'b00;
      end else begin
        v.regw = 1'b1;
        v.pcs = (rd == 4'hF);
      end
    end else if (op == 2'd1) begin
      if (c == 2) v.srcb = 2'd1;
      else if (c == 3) begin
        v.adr = 1'b1;
        v.memw = !f[0];
      end else begin
        v.res = 2'd1;
        v.regw = 1'b1;
        v.pcs = (rd == 4'hF);
      end
    end else begin
      v.srcb = 2'd1;
      v.res = 2'd2;
      v.pcs = 1'b1;
    end
    return v;
  endfunction
  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd, input int n);
    Op = op;
    Funct = f;
    Rd = rd;
    for (int c = 0; c < n; c++) exp_q.push_back(model(op, f, rd, c));
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check_reset(input string tag);
    vec_t e;
    e = '0;
    e.srca = 1'b1;
    e.srcb = 2'd2;
    e.res = 2'd2;
    e.imm = Op;
    e.rsrc = {Op == 2'd1, Op == 2'd2};
    n_checks++;
    if (actual !== e) begin
      n_fail++;
      $display("FAIL reset_%s: got %h expected %h", tag, actual, e);
    end
  endtask
  always @(negedge clk) begin
    vec_t e;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (actual !== e) begin
        n_fail++;
        $display("FAIL cycle @%0t: got %h expected %h (Op=%b Funct=%b Rd=%h)",
                 $time, actual, e, Op, Funct, Rd);
      end
    end
  end
  initial begin
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] rd;
    repeat (2) @(posedge clk);
    #2 check_reset("por");
    @(posedge clk);
    #1 reset = 1'b0;
    issue(2'd0, 6'b101001, 4'd1, 4);
    issue(2'd0, 6'b000001, 4'd2, 4);
    issue(2'd0, 6'b000100, 4'hF, 4);
    issue(2'd1, 6'b000001, 4'd3, 5);
    issue(2'd1, 6'b000000, 4'd4, 4);
    issue(2'd1, 6'b011001, 4'hF, 5);
    issue(2'd2, 6'b000000, 4'd0, 3);
    issue(2'd3, 6'b111111, 4'hF, 2);
    issue(2'd0, 6'b010101, 4'd5, 4);
    issue(2'd0, 6'b011001, 4'd6, 4);
    issue(2'd0, 6'b001000, 4'hF, 3);
    #1 reset = 1'b1;
    #1 check_reset("mid_aluwb");
    @(posedge clk);
    #1 reset = 1'b0;
    issue(2'd0, 6'b101001, 4'hF, 4);
    repeat (300) begin
      op = 2'($urandom_range(0, 3));
      f = 6'($urandom);
      rd = 4'($urandom);
      issue(op, f, rd, lat(op, f));
    end
    repeat (10) if (exp_q.size() > 0) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
